data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter MEM_BYTES SHALL be: MEM_BYTES, default 128, byte capacity of the attached data memory.
REQ-002 Clock and reset SHALL be: one clock; reset is synchronous and active-high (Clock, Reset).
REQ-003 Ports SHALL be, in order:
- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous active-high reset.
- a_req  in  1  port A (CPU) request.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  16  port A byte address.
- a_wdata  in  16  port A write data, big-endian.
- a_gnt  out  1  port A request accepted (1-cycle pulse).
- a_done  out  1  port A transaction complete (1-cycle pulse).
- a_err  out  1  port A address error, valid with a_done.
- a_rdata  out  16  port A read data, valid with a_done.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_err, b_rdata: same widths and meanings for port B (DMA/debug).
- mem_Address  out  16  to memory Address.
- mem_WriteData  out  16  to memory WriteData.
- mem_MemWrite  out  1  to memory MemWrite.
- mem_MemRead  out  1  to memory MemRead.
- mem_ReadData  in  16  from memory ReadData (combinational read).

Function
REQ-004 The FSM SHALL have states IDLE, ACCESS, DONE; IDLE->ACCESS on any request; ACCESS->DONE always; DONE->IDLE always.
REQ-005 In IDLE, at the posedge where a_req or b_req is high, the arbiter SHALL select one port, latch its we/addr/wdata, and enter ACCESS.
REQ-006 With both requests high, the selected port SHALL be the one not granted last (round-robin); with one request, that port wins.
REQ-007 The last-granted register SHALL reset to B, so A wins the first contention after reset.
REQ-008 xx_gnt SHALL pulse high for exactly the ACCESS cycle of the selected port; requesters may drop req or change addr/wdata after gnt.
REQ-009 In ACCESS, mem_Address/mem_WriteData SHALL carry the latched values; mem_MemWrite = latched we; mem_MemRead = !latched we.
REQ-010 At the posedge ending ACCESS, mem_ReadData SHALL be registered for a read (0 for a write).
REQ-011 In DONE, xx_done SHALL pulse one cycle on the selected port; xx_rdata SHALL hold the registered value until that port's next done.
REQ-012 Outside ACCESS, mem_MemWrite and mem_MemRead SHALL be 0 and mem_Address/mem_WriteData SHALL be 0.
REQ-013 An address is out of range when addr > MEM_BYTES-2 (16-bit unsigned compare; covers addr+1 overflow and wrap at 0xFFFF).
REQ-014 Out-of-range SHALL still take IDLE->ACCESS->DONE, with mem_MemWrite=0, mem_MemRead=0 and rdata=0, and assert xx_err with xx_done.
REQ-015 Odd in-range addresses SHALL be legal (byte-addressed, no alignment check).
REQ-016 Latency SHALL be: req sampled at edge N, gnt in cycle N+1, done in cycle N+2; peak throughput one transaction per 3 cycles.
REQ-017 Requests arriving during ACCESS/DONE SHALL wait; still-high req SHALL be arbitrated in the next IDLE cycle.

Reset
REQ-018 Reset SHALL force IDLE and last-grant=B, and zero all outputs (gnt, done, err, rdata, mem_*), with priority over any other event.
REQ-019 Reset during ACCESS SHALL suppress mem_MemWrite from the following cycle; the aborted transaction SHALL produce no done.

Structure
REQ-020 Package data_mem_arb_pkg SHALL hold the state enum, default MEM_BYTES, and port ID constants PORT_A/PORT_B.
REQ-021 Round-robin selection SHALL be sub-module rr_arbiter2 (two requests, grant vector, last-grant register); the rest stays in data_mem_arbiter.

Verification
REQ-022 A write 0x1234 @0x0010, then A read @0x0010 -> memory bytes [0x10]=0x12, [0x11]=0x34; a_rdata=0x1234 with a_done, a_err=0.
REQ-023 a_req and b_req held high from reset -> grants alternate A,B,A,B every 3 cycles; no port starved.
REQ-024 B write @0x007F and @0xFFFF -> b_done with b_err=1, mem_MemWrite never asserted, memory unchanged.
REQ-025 B write 0xBEEF @0x007E (top legal) -> succeeds, b_err=0; readback 0xBEEF.
REQ-026 Reset asserted during A's write ACCESS -> no a_done, FSM IDLE next cycle, all outputs 0.
REQ-027 A single read @0x0005 -> a_gnt at N+1, a_done at N+2, mem_MemRead high only in N+1.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package data_mem_arb_pkg;

  // Transaction sequencer states: arbitrate, drive memory, report completion
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Default byte capacity of the attached data memory
  localparam int MEM_BYTES_DEFAULT = 128;

  // Bit positions of each requester inside request/grant vectors
  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

  // A 16-bit access touches addr and addr+1, so the last legal start is
  // mem_bytes-2; the unsigned compare also rejects 0xFFFF (addr+1 wrap).
  function automatic logic addr_out_of_range(input logic [15:0] addr,
                                             input int          mem_bytes);
    return addr > 16'(mem_bytes - 2);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a last-grant register.
// Latency: grant vector is combinational from req; history updates on posedge.
// Backpressure: history only advances when the caller accepts a grant (advance).
module rr_arbiter2
  import data_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 when port B was granted most recently; resets to B so A wins first
  logic last_b;

  // Pick the port not granted last when both ask; a lone request always wins
  always_comb begin
    gnt = 2'b00;
    if (req[PORT_A] && req[PORT_B]) begin
      if (last_b) begin
        gnt[PORT_A] = 1'b1;
      end else begin
        gnt[PORT_B] = 1'b1;
      end
    end else begin
      gnt = req;
    end
  end

  // Remember the winner whenever a grant is actually taken
  always_ff @(posedge clk) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (advance && (req != 2'b00)) begin
      last_b <= gnt[PORT_B];
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates CPU (A) and DMA/debug (B) ports onto one 16-bit big-endian data memory.
// Latency: req sampled at edge N, gnt during cycle N+1, done/rdata during cycle N+2.
// Backpressure: one transaction per 3 cycles; a loser keeps req high until its gnt.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
)
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_gnt,
  output logic        a_done,
  output logic        a_err,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_gnt,
  output logic        b_done,
  output logic        b_err,
  output logic [15:0] b_rdata,
  output logic [15:0] mem_Address,
  output logic [15:0] mem_WriteData,
  output logic        mem_MemWrite,
  output logic        mem_MemRead,
  input  logic [15:0] mem_ReadData
);

  state_t      state;
  logic        sel_b;      // selected port for the transaction in flight
  logic        lat_we;     // latched direction
  logic        lat_oor;    // latched out-of-range flag
  logic [1:0]  req_vec;
  logic [1:0]  gnt_vec;
  logic        arb_advance;
  logic        pick_b;
  logic        pick_we;
  logic [15:0] pick_addr;
  logic [15:0] pick_wdata;
  logic        pick_oor;
  logic [15:0] cap_rdata;

  assign req_vec[PORT_A] = a_req;
  assign req_vec[PORT_B] = b_req;

  // Arbitration history only moves when the sequencer can accept a request
  assign arb_advance = (state == IDLE);

  rr_arbiter2 u_rr (
    .clk     (Clock),
    .rst     (Reset),
    .req     (req_vec),
    .advance (arb_advance),
    .gnt     (gnt_vec)
  );

  assign pick_b     = gnt_vec[PORT_B];
  assign pick_we    = pick_b ? b_we    : a_we;
  assign pick_addr  = pick_b ? b_addr  : a_addr;
  assign pick_wdata = pick_b ? b_wdata : a_wdata;
  assign pick_oor   = addr_out_of_range(pick_addr, MEM_BYTES);

  // Only a legal read returns memory data; writes and rejected accesses give 0
  assign cap_rdata = (!lat_we && !lat_oor) ? mem_ReadData : 16'h0000;

  // Sequencer: every output is registered and defaults to 0 outside its pulse
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= IDLE;
      sel_b         <= 1'b0;
      lat_we        <= 1'b0;
      lat_oor       <= 1'b0;
      a_gnt         <= 1'b0;
      a_done        <= 1'b0;
      a_err         <= 1'b0;
      a_rdata       <= 16'h0000;
      b_gnt         <= 1'b0;
      b_done        <= 1'b0;
      b_err         <= 1'b0;
      b_rdata       <= 16'h0000;
      mem_Address   <= 16'h0000;
      mem_WriteData <= 16'h0000;
      mem_MemWrite  <= 1'b0;
      mem_MemRead   <= 1'b0;
    end else begin
      a_gnt         <= 1'b0;
      b_gnt         <= 1'b0;
      a_done        <= 1'b0;
      b_done        <= 1'b0;
      a_err         <= 1'b0;
      b_err         <= 1'b0;
      mem_Address   <= 16'h0000;
      mem_WriteData <= 16'h0000;
      mem_MemWrite  <= 1'b0;
      mem_MemRead   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_vec != 2'b00) begin
            sel_b         <= pick_b;
            lat_we        <= pick_we;
            lat_oor       <= pick_oor;
            a_gnt         <= !pick_b;
            b_gnt         <= pick_b;
            mem_Address   <= pick_addr;
            mem_WriteData <= pick_wdata;
            // A rejected address still runs the full sequence, but never strobes memory
            mem_MemWrite  <= pick_we && !pick_oor;
            mem_MemRead   <= !pick_we && !pick_oor;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (sel_b) begin
            b_done  <= 1'b1;
            b_err   <= lat_oor;
            b_rdata <= cap_rdata;
          end else begin
            a_done  <= 1'b1;
            a_err   <= lat_oor;
            a_rdata <= cap_rdata;
          end
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized two-port traffic vs a byte-array model.
// Latency: checks gnt one cycle after sampling and done one cycle after gnt.
// Backpressure: losing requester holds req until granted; every wait is cycle-bounded.
module tb_data_mem_arbiter;

  localparam int MEM_BYTES = 128;

  logic        Clock;
  logic        Reset;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] mem_Address, mem_WriteData, mem_ReadData;
  logic        mem_MemWrite, mem_MemRead;

  int errors = 0;
  int checks = 0;

  // Attached memory (environment) and the reference byte image
  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] exp_mem [MEM_BYTES];

  int wr_cnt = 0;
  int rd_cnt = 0;
  int a_done_cnt = 0;
  int model_last;  // port granted last by the reference arbitration rule

  data_mem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .Clock(Clock), .Reset(Reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
    .mem_Address(mem_Address), .mem_WriteData(mem_WriteData),
    .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
    .mem_ReadData(mem_ReadData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Big-endian memory: synchronous write, combinational read
  always @(posedge Clock) begin
    if (mem_MemWrite && (int'(mem_Address) <= MEM_BYTES - 2)) begin
      mem[int'(mem_Address)]     <= mem_WriteData[15:8];
      mem[int'(mem_Address) + 1] <= mem_WriteData[7:0];
    end
  end

  always_comb begin
    mem_ReadData = 16'h0000;
    if (int'(mem_Address) <= MEM_BYTES - 2)
      mem_ReadData = {mem[int'(mem_Address)], mem[int'(mem_Address) + 1]};
  end

  // Activity monitors sampled away from the active edge
  always @(negedge Clock) begin
    if (mem_MemWrite === 1'b1) wr_cnt++;
    if (mem_MemRead === 1'b1) rd_cnt++;
    if (a_done === 1'b1) a_done_cnt++;
  end

  function automatic logic get_gnt(input int p);
    return (p == 1) ? b_gnt : a_gnt;
  endfunction
  function automatic logic get_done(input int p);
    return (p == 1) ? b_done : a_done;
  endfunction
  function automatic logic get_err(input int p);
    return (p == 1) ? b_err : a_err;
  endfunction
  function automatic logic [15:0] get_rdata(input int p);
    return (p == 1) ? b_rdata : a_rdata;
  endfunction

  task automatic drive_port(input int p, input logic req, input logic we,
                            input logic [15:0] addr, input logic [15:0] wdata);
    if (p == 1) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
    end
  endtask

  // Reference: a 16-bit access at addr uses bytes addr, addr+1; anything past the end is an error
  task automatic model_apply(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                             output logic e_err, output logic [15:0] e_rdata);
    int a;
    a = int'(addr);
    e_err = (a + 1 >= MEM_BYTES);
    e_rdata = 16'h0000;
    if (!e_err) begin
      if (we) begin
        exp_mem[a]     = wdata[15:8];
        exp_mem[a + 1] = wdata[7:0];
      end else begin
        e_rdata = {exp_mem[a], exp_mem[a + 1]};
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge Clock);
    Reset = 1'b1;
    drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    model_last = 1;
  endtask

  // One transaction on one port; reports observed gnt latency and done-cycle outputs
  task automatic run_txn(input int p, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, output int gnt_lat,
                         output logic got_done, output logic got_err,
                         output logic [15:0] got_rdata, output logic e_err,
                         output logic [15:0] e_rdata);
    @(negedge Clock);
    drive_port(p, 1'b1, we, addr, wdata);
    gnt_lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clock);
      if (get_gnt(p) === 1'b1) begin
        gnt_lat = c;
        break;
      end
    end
    drive_port(p, 1'b0, 1'b0, 16'h0, 16'h0);
    got_done = 1'b0; got_err = 1'b0; got_rdata = 16'h0;
    if (gnt_lat > 0) begin
      @(negedge Clock);
      got_done = get_done(p); got_err = get_err(p); got_rdata = get_rdata(p);
      model_last = p;
    end
    model_apply(we, addr, wdata, e_err, e_rdata);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive_port(0, 1'b1, 1'b1, 16'h0010, 16'h5555);
    drive_port(1, 1'b1, 1'b0, 16'h0020, 16'h0);
    repeat (3) @(negedge Clock);
    checks++;
    if ({a_gnt, a_done, a_err, b_gnt, b_done, b_err, mem_MemWrite, mem_MemRead} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {a_gnt, a_done, a_err, b_gnt, b_done, b_err, mem_MemWrite, mem_MemRead});
    end
    checks++;
    if ({a_rdata, b_rdata, mem_Address, mem_WriteData} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {a_rdata, b_rdata, mem_Address, mem_WriteData});
    end
    drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
    Reset = 1'b0;
    model_last = 1;
  endtask

  task automatic test_latency();
    int rd0;
    logic e_err;
    logic [15:0] e_rd;
    apply_reset();
    rd0 = rd_cnt;
    drive_port(0, 1'b1, 1'b0, 16'h0005, 16'h0);
    @(negedge Clock);
    checks++;
    if ({a_gnt, mem_MemRead, mem_MemWrite, mem_Address} !== {1'b1, 1'b1, 1'b0, 16'h0005}) begin
      errors++;
      $display("FAIL lat_access: got gnt=%b rd=%b wr=%b addr=%h expected 1 1 0 0005",
               a_gnt, mem_MemRead, mem_MemWrite, mem_Address);
    end
    drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
    model_apply(1'b0, 16'h0005, 16'h0, e_err, e_rd);
    model_last = 0;
    @(negedge Clock);
    checks++;
    if ({a_done, a_gnt, mem_MemRead, a_err, a_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, e_rd}) begin
      errors++;
      $display("FAIL lat_done: got done=%b gnt=%b rd=%b err=%b rdata=%h expected 1 0 0 0 %h",
               a_done, a_gnt, mem_MemRead, a_err, a_rdata, e_rd);
    end
    @(negedge Clock);
    checks++;
    if (rd_cnt - rd0 !== 1) begin
      errors++;
      $display("FAIL lat_read_cycles: got %0d expected 1", rd_cnt - rd0);
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic d, e, ee;
    logic [15:0] r, er;
    run_txn(0, 1'b1, 16'h0010, 16'h1234, lat, d, e, r, ee, er);
    checks++;
    if ({d, e, mem[16], mem[17]} !== {1'b1, 1'b0, 8'h12, 8'h34}) begin
      errors++;
      $display("FAIL wr_0010: got done=%b err=%b bytes=%h%h expected 1 0 1234", d, e, mem[16], mem[17]);
    end
    run_txn(0, 1'b0, 16'h0010, 16'h0, lat, d, e, r, ee, er);
    checks++;
    if ({d, e, r} !== {1'b1, 1'b0, 16'h1234}) begin
      errors++;
      $display("FAIL rd_0010: got done=%b err=%b rdata=%h expected 1 0 1234", d, e, r);
    end
    repeat (2) @(negedge Clock);
    checks++;
    if (a_rdata !== 16'h1234) begin
      errors++;
      $display("FAIL rdata_hold: got %h expected 1234", a_rdata);
    end
    run_txn(0, 1'b1, 16'h0011, 16'hA55A, lat, d, e, r, ee, er);
    run_txn(0, 1'b0, 16'h0011, 16'h0, lat, d, e, r, ee, er);
    checks++;
    if ({d, e, r} !== {1'b1, 1'b0, 16'hA55A}) begin
      errors++;
      $display("FAIL rd_odd_0011: got done=%b err=%b rdata=%h expected 1 0 a55a", d, e, r);
    end
  endtask

  task automatic test_round_robin();
    int gp [$];
    int gc [$];
    Reset = 1'b1;
    @(negedge Clock);
    drive_port(0, 1'b1, 1'b0, 16'h0002, 16'h0);
    drive_port(1, 1'b1, 1'b0, 16'h0040, 16'h0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge Clock);
      if (a_gnt === 1'b1 || b_gnt === 1'b1) begin
        gp.push_back((b_gnt === 1'b1) ? 1 : 0);
        gc.push_back(c);
      end
    end
    drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(negedge Clock);
    model_last = (gp.size() > 0) ? gp[gp.size() - 1] : 1;
    checks++;
    if (gp.size() != 10) begin
      errors++;
      $display("FAIL rr_grant_count: got %0d expected 10", gp.size());
    end
    for (int k = 0; k < gp.size(); k++) begin
      checks++;
      if (gp[k] != (k % 2)) begin
        errors++;
        $display("FAIL rr_order[%0d]: got port %0d expected port %0d", k, gp[k], k % 2);
      end
      if (k > 0) begin
        checks++;
        if (gc[k] - gc[k - 1] != 3) begin
          errors++;
          $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", k, gc[k] - gc[k - 1]);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    int lat, w0;
    logic d, e, ee;
    logic [15:0] r, er;
    w0 = wr_cnt;
    run_txn(1, 1'b1, 16'h007F, 16'hAAAA, lat, d, e, r, ee, er);
    checks++;
    if ({d, e, r} !== {1'b1, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL oor_wr_007f: got done=%b err=%b rdata=%h expected 1 1 0000", d, e, r);
    end
    run_txn(1, 1'b1, 16'hFFFF, 16'h5555, lat, d, e, r, ee, er);
    checks++;
    if ({d, e} !== {1'b1, 1'b1}) begin
      errors++;
      $display("FAIL oor_wr_ffff: got done=%b err=%b expected 1 1", d, e);
    end
    run_txn(1, 1'b0, 16'h0080, 16'h0, lat, d, e, r, ee, er);
    checks++;
    if ({d, e, r} !== {1'b1, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL oor_rd_0080: got done=%b err=%b rdata=%h expected 1 1 0000", d, e, r);
    end
    checks++;
    if (wr_cnt - w0 != 0) begin
      errors++;
      $display("FAIL oor_memwrite: got %0d write cycles expected 0", wr_cnt - w0);
    end
  endtask

  task automatic test_top_legal();
    int lat;
    logic d, e, ee;
    logic [15:0] r, er;
    run_txn(1, 1'b1, 16'h007E, 16'hBEEF, lat, d, e, r, ee, er);
    checks++;
    if ({d, e, mem[126], mem[127]} !== {1'b1, 1'b0, 8'hBE, 8'hEF}) begin
      errors++;
      $display("FAIL top_wr_007e: got done=%b err=%b bytes=%h%h expected 1 0 beef", d, e, mem[126], mem[127]);
    end
    run_txn(1, 1'b0, 16'h007E, 16'h0, lat, d, e, r, ee, er);
    checks++;
    if ({d, e, r} !== {1'b1, 1'b0, 16'hBEEF}) begin
      errors++;
      $display("FAIL top_rd_007e: got done=%b err=%b rdata=%h expected 1 0 beef", d, e, r);
    end
  endtask

  task automatic test_reset_during_access();
    int d0, seen;
    logic [15:0] same, e_rd;
    logic e_err;
    same = {exp_mem[32], exp_mem[33]};  // rewriting current contents keeps the image valid
    d0 = a_done_cnt;
    @(negedge Clock);
    drive_port(0, 1'b1, 1'b1, 16'h0020, same);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      if (a_gnt === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL rst_acc_gnt: got no gnt expected gnt within 10 cycles");
    end
    Reset = 1'b1;
    drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge Clock);
    checks++;
    if ({a_gnt, a_done, a_err, b_gnt, b_done, b_err, mem_MemWrite, mem_MemRead,
         a_rdata, b_rdata, mem_Address, mem_WriteData} !== 72'h0) begin
      errors++;
      $display("FAIL rst_acc_outputs: got done=%b wr=%b addr=%h expected all zero",
               a_done, mem_MemWrite, mem_Address);
    end
    Reset = 1'b0;
    model_last = 1;
    drive_port(0, 1'b1, 1'b0, 16'h0020, 16'h0);
    @(negedge Clock);
    checks++;
    if (a_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_acc_idle: got gnt=%b expected 1 one cycle after reset", a_gnt);
    end
    drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
    model_apply(1'b0, 16'h0020, 16'h0, e_err, e_rd);
    model_last = 0;
    @(negedge Clock);
    checks++;
    if ({a_done, a_rdata} !== {1'b1, e_rd}) begin
      errors++;
      $display("FAIL rst_acc_readback: got done=%b rdata=%h expected 1 %h", a_done, a_rdata, e_rd);
    end
    @(negedge Clock);
    checks++;
    if (a_done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL rst_acc_no_done: got %0d done pulses expected 1", a_done_cnt - d0);
    end
  endtask

  task automatic test_random();
    logic        t_we    [2];
    logic [15:0] t_addr  [2];
    logic [15:0] t_wdata [2];
    logic [1:0]  pend;
    int          g_prev, guard, g, want_w, r;
    logic        e_err;
    logic [15:0] e_rd;
    apply_reset();
    for (int it = 0; it < 30; it++) begin
      pend = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        r = $urandom_range(0, 9);
        if (r < 8)       t_addr[p] = 16'($urandom_range(0, MEM_BYTES - 2));
        else if (r == 8) t_addr[p] = 16'(MEM_BYTES - 1 + $urandom_range(0, 3));
        else             t_addr[p] = 16'hFFF0 + 16'($urandom_range(0, 15));
        t_we[p]    = 1'($urandom_range(0, 1));
        t_wdata[p] = 16'($urandom);
      end
      @(negedge Clock);
      for (int p = 0; p < 2; p++)
        if (pend[p]) drive_port(p, 1'b1, t_we[p], t_addr[p], t_wdata[p]);
      g_prev = -1;
      guard = 0;
      while ((pend != 2'b00 || g_prev >= 0) && guard < 40) begin
        @(negedge Clock);
        guard++;
        if (g_prev >= 0) begin
          checks++;
          if ({get_done(g_prev), get_done(1 - g_prev), get_err(g_prev), get_rdata(g_prev)}
              !== {1'b1, 1'b0, e_err, e_rd}) begin
            errors++;
            $display("FAIL rand_done[%0d]: port %0d got done=%b err=%b rdata=%h expected 1 %b %h",
                     it, g_prev, get_done(g_prev), get_err(g_prev), get_rdata(g_prev), e_err, e_rd);
          end
          g_prev = -1;
        end
        if (a_gnt === 1'b1 || b_gnt === 1'b1) begin
          g = (b_gnt === 1'b1) ? 1 : 0;
          want_w = (pend == 2'b11) ? (1 - model_last) : (pend[1] ? 1 : 0);
          checks++;
          if ((g != want_w) || (a_gnt === b_gnt)) begin
            errors++;
            $display("FAIL rand_winner[%0d]: got a_gnt=%b b_gnt=%b expected port %0d",
                     it, a_gnt, b_gnt, want_w);
          end
          model_last = g;
          model_apply(t_we[g], t_addr[g], t_wdata[g], e_err, e_rd);
          drive_port(g, 1'b0, 1'b0, 16'h0, 16'h0);
          pend[g] = 1'b0;
          g_prev = g;
        end
      end
      if (guard >= 40) begin
        checks++;
        errors++;
        $display("FAIL rand_timeout[%0d]: got pending=%b expected all served", it, pend);
        drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
      end
    end
  endtask

  task automatic test_mem_image();
    int bad;
    bad = 0;
    for (int i = 0; i < MEM_BYTES; i++)
      if (mem[i] !== exp_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mem_image: got %0d differing bytes expected 0", bad);
    end
  endtask

  initial begin
    Reset = 1'b1;
    drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
    model_last = 1;
    for (int i = 0; i < MEM_BYTES; i++) begin
      exp_mem[i] = 8'($urandom);
      mem[i] <= exp_mem[i];
    end
    test_reset();
    test_latency();
    test_write_read();
    test_round_robin();
    test_out_of_range();
    test_mem_image();
    test_top_legal();
    test_reset_during_access();
    test_random();
    test_mem_image();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
